piso_serializer: RTL and testbench

Parallel-in serial-out transmitter. It is the transmit-side counterpart to the team's serial-in shift registers and deserializers.
- Accepts an N-bit word over a valid/ready handshake.
- Shifts the word out one bit at a time, each bit held for DIV clock cycles, with frame markers.
- Supports gapless back-to-back words so a downstream shift-register receiver sees a continuous bit stream.

---
 rtl/piso_serializer_if.sv | 23 ++
 rtl/piso_serializer.sv | 91 +++++++++
 tb/tb_piso_serializer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle between a word source, the serializer and the serial sink.
interface piso_serializer_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         flush;
  logic         sout;
  logic         sout_valid;
  logic         sof;
  logic         done;

  modport slave (
    input  din, din_valid, flush,
    output din_ready, sout, sout_valid, sof, done
  );

  modport master (
    output din, din_valid, flush,
    input  din_ready, sout, sout_valid, sof, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: N-bit word per handshake, each bit held DIV cycles,
// with sof/done frame markers and gapless reload in the final cycle of a word.
module piso_serializer #(
  parameter int unsigned N          = 8,
  parameter int unsigned DIV        = 1,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  piso_serializer_if.slave  bus
);
  localparam int unsigned BW = $clog2(N);
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_d;
  logic [N-1:0]   shreg, shreg_d;
  logic [BW-1:0]  bit_cnt, bit_d;
  logic [DW-1:0]  div_cnt, div_d;
  logic           last_bit, last_div, accept, head_d;

  assign last_bit = (bit_cnt == BW'(N - 1));
  assign last_div = (div_cnt == DW'(DIV - 1));

  // Ready in idle, or in the last cycle of a word so the next one follows with no gap.
  assign bus.din_ready = !reset && !bus.flush &&
                         ((state == IDLE) || ((state == SHIFT) && last_bit && last_div));
  assign accept = bus.din_valid && bus.din_ready;

  // Next-state and datapath decode.
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    bit_d   = bit_cnt;
    div_d   = div_cnt;
    if (bus.flush) begin
      state_d = IDLE;
      shreg_d = '0;
      bit_d   = '0;
      div_d   = '0;
    end else if (accept) begin
      state_d = SHIFT;
      shreg_d = bus.din;
      bit_d   = '0;
      div_d   = '0;
    end else if (state == SHIFT) begin
      if (last_div) begin
        div_d = '0;
        if (last_bit) begin
          state_d = IDLE;
          bit_d   = '0;
        end else begin
          bit_d   = bit_cnt + BW'(1);
          shreg_d = MSB_FIRST ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};
        end
      end else begin
        div_d = div_cnt + DW'(1);
      end
    end
  end

  assign head_d = MSB_FIRST ? shreg_d[N-1] : shreg_d[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Counters, shift register and registered serial-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg          <= '0;
      bit_cnt        <= '0;
      div_cnt        <= '0;
      bus.sout       <= IDLE_LEVEL;
      bus.sout_valid <= 1'b0;
      bus.sof        <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      shreg          <= shreg_d;
      bit_cnt        <= bit_d;
      div_cnt        <= div_d;
      bus.sout       <= (state_d == SHIFT) ? head_d : IDLE_LEVEL;
      bus.sout_valid <= (state_d == SHIFT);
      bus.sof        <= (state_d == SHIFT) && (bit_d == '0);
      bus.done       <= (state_d == SHIFT) && (bit_d == BW'(N - 1)) && (div_d == DW'(DIV - 1));
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: per-cycle vector table plus hand-written corner sequences.
module tb_piso_serializer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  piso_serializer_if #(.N(8)) a0 ();
  piso_serializer_if #(.N(8)) a1 ();
  piso_serializer_if #(.N(8)) a2 ();

  piso_serializer #(.N(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (.clk(clk), .reset(reset), .bus(a0));
  piso_serializer #(.N(8), .DIV(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u1 (.clk(clk), .reset(reset), .bus(a1));
  piso_serializer #(.N(8), .DIV(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u2 (.clk(clk), .reset(reset), .bus(a2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp packs {sout, sout_valid, sof, done, din_ready} for the cycle the inputs are applied in.
  typedef struct {
    logic [7:0] din;
    logic       v;
    logic       f;
    logic [4:0] exp;
    int         tag;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] obs0();
    return {a0.sout, a0.sout_valid, a0.sof, a0.done, a0.din_ready};
  endfunction

  task automatic run_u2(input logic [7:0] word, input logic [7:0] seq, input string nm);
    logic [4:0] e;
    @(negedge clk);
    a2.din = word; a2.din_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      a2.din_valid = 1'b0;
      #1;
      e = (c <= 8) ? {seq[8-c], 1'b1, c == 1, c == 8} : 4'b0000;
      chk($sformatf("%s_c%0d", nm, c), {a2.sout, a2.sout_valid, a2.sof, a2.done}, e);
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [4:0] e;
    int         sv_cnt;
    checks = 0; failures = 0;
    reset = 1'b1;
    a0.din = '0; a0.din_valid = 1'b1; a0.flush = 1'b0;
    a1.din = '0; a1.din_valid = 1'b0; a1.flush = 1'b0;
    a2.din = '0; a2.din_valid = 1'b0; a2.flush = 1'b0;

    // Test 1: 0xA5, DIV=1, MSB first.
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 5'b00001, 1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b11100, 1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01000, 1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b11000, 1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01000, 1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01000, 1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b11000, 1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01000, 1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b11011, 1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b00001, 1});
    // Test 3: 0xFF then 0x00 back-to-back with din_valid held.
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 5'b00001, 3});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 5'b11100, 3});
    for (int i = 0; i < 6; i++) vecs.push_back('{8'h00, 1'b1, 1'b0, 5'b11000, 3});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 5'b11011, 3});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01100, 3});
    for (int i = 0; i < 6; i++) vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01000, 3});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01011, 3});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b00001, 3});
    // Test 5: flush in cycle 4 beats a pending 0x3C, which then goes out whole.
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 5'b00001, 5});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b11100, 5});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01000, 5});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b11000, 5});
    vecs.push_back('{8'h3C, 1'b1, 1'b1, 5'b01000, 5});
    vecs.push_back('{8'h3C, 1'b1, 1'b0, 5'b00001, 5});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01100, 5});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01000, 5});
    for (int i = 0; i < 4; i++) vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b11000, 5});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01000, 5});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b01011, 5});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 5'b00001, 5});

    #3;
    chk("reset_u0", 32'(obs0()), 32'(5'b00000));
    chk("reset_u1", 32'({a1.sout, a1.sout_valid, a1.sof, a1.done}), 32'(4'b0000));
    @(negedge clk);
    @(negedge clk);
    a0.din_valid = 1'b0;
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      a0.din = vecs[i].din; a0.din_valid = vecs[i].v; a0.flush = vecs[i].f;
      #1;
      chk($sformatf("t%0d_v%0d", vecs[i].tag, i), 32'(obs0()), 32'(vecs[i].exp));
    end
    a0.din_valid = 1'b0; a0.flush = 1'b0;

    // Test 2: DIV=3, each bit held three cycles, 24 valid cycles.
    pat = 8'hA5; sv_cnt = 0;
    @(negedge clk);
    a1.din = pat; a1.din_valid = 1'b1;
    #1 chk("t2_ready", 32'(a1.din_ready), 32'(1));
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      a1.din_valid = 1'b0;
      #1;
      if (a1.sout_valid) sv_cnt++;
      e = (c <= 24) ? {pat[7 - (c - 1) / 3], 1'b1, c <= 3, c == 24, c == 24} : 5'b00001;
      chk($sformatf("t2_c%0d", c), 32'({a1.sout, a1.sout_valid, a1.sof, a1.done, a1.din_ready}), 32'(e));
    end
    chk("t2_valid_cycles", 32'(sv_cnt), 32'(24));

    // Test 4: LSB first.
    run_u2(8'h01, 8'b1000_0000, "t4_01");
    run_u2(8'h80, 8'b0000_0001, "t4_80");

    // Test 6: async reset while the third bit of 0xA5 is on the line.
    @(negedge clk);
    a0.din = 8'hA5; a0.din_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      a0.din_valid = 1'b0;
    end
    #1 chk("t6_pre", 32'(obs0()), 32'(5'b11000));
    a0.din = 8'h5A; a0.din_valid = 1'b1;
    #1 reset = 1'b1;
    #1 chk("t6_reset_now", 32'(obs0()), 32'(5'b00000));
    @(negedge clk);
    #1 chk("t6_reset_hold", 32'(obs0()), 32'(5'b00000));
    reset = 1'b0;
    #1 chk("t6_ready_after", 32'(a0.din_ready), 32'(1));
    pat = 8'h5A;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      a0.din_valid = 1'b0;
      #1;
      e = (c <= 8) ? {pat[8 - c], 1'b1, c == 1, c == 8, c == 8} : 5'b00001;
      chk($sformatf("t6_c%0d", c), 32'(obs0()), 32'(e));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
